// File: rtl/wb_arb_pkg.sv
// -----------------------------------------------------------------------------
// wb_arb_pkg
// Shared types and default constants for the vector write-port arbiter.
//   arb_state_e : arbitration state (IDLE / PEND / FORCE)
//   wb_entry_t  : one pending-buffer entry at the default geometry
//   *_DEF       : default width, depth and starvation-limit constants
// Configuration macro used elsewhere: WB_PORT_ARBITER_PERF_EN.
// -----------------------------------------------------------------------------
package wb_arb_pkg;

  localparam int unsigned V_DEF        = 256;
  localparam int unsigned R_DEF        = 5;
  localparam int unsigned DEPTH_DEF    = 2;
  localparam int unsigned MAX_WAIT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FORCE = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic             valid;
    logic [R_DEF-1:0] addr;
    logic [V_DEF-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_pend_fifo.sv
// -----------------------------------------------------------------------------
// wb_pend_fifo
// Pending buffer for long-latency vector results that lost the write port.
// Circular buffer with per-entry valid bit; a valid bit can be cleared in
// place (write-after-write squash) without disturbing ordering.
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   push/push_addr/data  append an entry at the tail (valid=1)
//   pop                  retire the head entry (written or squashed)
//   squash_en/addr       clear valid of every buffered entry matching addr
//   head_valid/addr/data current head entry
//   count, count_next    occupancy now and after this cycle's push/pop
//   any_valid            OR of all entry valid bits
//   squash_hit           at least one entry was squashed this cycle
// -----------------------------------------------------------------------------
module wb_pend_fifo
  import wb_arb_pkg::*;
#(
  parameter int unsigned V     = V_DEF,
  parameter int unsigned R     = R_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [R-1:0]             push_addr,
  input  logic [V-1:0]             push_data,
  input  logic                     pop,
  input  logic                     squash_en,
  input  logic [R-1:0]             squash_addr,
  output logic                     head_valid,
  output logic [R-1:0]             head_addr,
  output logic [V-1:0]             head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   count_next,
  output logic                     any_valid,
  output logic                     squash_hit
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [R-1:0]     addr_q [DEPTH];
  logic [V-1:0]     data_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] hit;

  // Per-entry address compare against the pipeline destination.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_cmp
      assign hit[gi] = squash_en & valid_q[gi] & (addr_q[gi] == squash_addr);
    end
  endgenerate

  always_comb begin
    valid_d  = valid_q & ~hit;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    // Valid is cleared on pop so any_valid never sees a stale retired slot.
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + 1'b1;
    end
    // The tail slot is never occupied when a push is allowed, so it cannot
    // collide with the pop or squash updates above.
    if (push) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload needs no reset: it is only observed through a set valid bit.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= push_addr;
      data_q[wr_ptr_q] <= push_data;
    end
  end

  assign head_valid = valid_q[rd_ptr_q];
  assign head_addr  = addr_q[rd_ptr_q];
  assign head_data  = data_q[rd_ptr_q];
  assign count      = count_q;
  assign count_next = count_d;
  assign any_valid  = |valid_q;
  assign squash_hit = |hit;

endmodule

// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
// Shares the vector register-file write port between the pipeline writeback
// (fixed priority) and a long-latency requester with a valid/ready handshake.
// Requester results that lose the port are buffered and drained in free
// cycles; a starving head raises ArbStall to request a writeback bubble.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   RegWriteVWi/WA3Wi/ResultVWi    pipeline vector write
//   LvValid/LvReady/LvWA3/LvData   long-latency requester handshake
//   WEV3/WAV3/WDV3                 register-file write port
//   ArbStall                       bubble request to the hazard unit
//   PendBusy                       a valid entry is buffered
//   PerfStall/PerfSquash/PerfBypass  saturating counters, only when the
//                                  macro WB_PORT_ARBITER_PERF_EN is defined
// -----------------------------------------------------------------------------
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned V        = V_DEF,
  parameter int unsigned R        = R_DEF,
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         RegWriteVWi,
  input  logic [R-1:0] WA3Wi,
  input  logic [V-1:0] ResultVWi,
  input  logic         LvValid,
  output logic         LvReady,
  input  logic [R-1:0] LvWA3,
  input  logic [V-1:0] LvData,
  output logic         WEV3,
  output logic [R-1:0] WAV3,
  output logic [V-1:0] WDV3,
  output logic         ArbStall,
  output logic         PendBusy
`ifdef WB_PORT_ARBITER_PERF_EN
  ,
  output logic [31:0]  PerfStall,
  output logic [31:0]  PerfSquash,
  output logic [31:0]  PerfBypass
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned WW = $clog2(MAX_WAIT + 1);

  logic          head_valid;
  logic [R-1:0]  head_addr;
  logic [V-1:0]  head_data;
  logic [CW-1:0] count, count_next;
  logic          any_valid, squash_hit;
  logic          buf_empty, xfer, in_discard, bypass, push, pop;

  arb_state_e    state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;

  // Ready depends on registered occupancy only; held low during reset so a
  // requester cannot sneak a bypass write through while the port is reset.
  assign buf_empty  = (count == '0);
  assign LvReady    = rst & (count < CW'(DEPTH));
  assign xfer       = LvValid & LvReady;
  // Same-cycle pipeline write to the same register makes the result stale.
  assign in_discard = xfer & RegWriteVWi & (LvWA3 == WA3Wi);
  assign bypass     = xfer & ~RegWriteVWi & buf_empty;
  assign push       = xfer & ~bypass & ~in_discard;
  // Any non-pipeline cycle retires the head: written if valid, dropped if not.
  assign pop        = ~RegWriteVWi & ~buf_empty;

  wb_pend_fifo #(
    .V     (V),
    .R     (R),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_addr   (LvWA3),
    .push_data   (LvData),
    .pop         (pop),
    .squash_en   (RegWriteVWi),
    .squash_addr (WA3Wi),
    .head_valid  (head_valid),
    .head_addr   (head_addr),
    .head_data   (head_data),
    .count       (count),
    .count_next  (count_next),
    .any_valid   (any_valid),
    .squash_hit  (squash_hit)
  );

  // Port select.
  always_comb begin
    WEV3 = 1'b0;
    WAV3 = '0;
    WDV3 = '0;
    if (RegWriteVWi) begin
      WEV3 = 1'b1;
      WAV3 = WA3Wi;
      WDV3 = ResultVWi;
    end else if (!buf_empty && head_valid) begin
      WEV3 = 1'b1;
      WAV3 = head_addr;
      WDV3 = head_data;
    end else if (bypass) begin
      WEV3 = 1'b1;
      WAV3 = LvWA3;
      WDV3 = LvData;
    end
  end

  // Wait counter: cycles the valid head lost the port; saturates at MAX_WAIT.
  always_comb begin
    wait_d = wait_q;
    if (pop) begin
      wait_d = '0;
    end else if (!buf_empty && head_valid && RegWriteVWi && (wait_q < WW'(MAX_WAIT))) begin
      wait_d = wait_q + 1'b1;
    end
  end

  // FSM: state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (count_next != '0) state_d = PEND;
      end
      PEND: begin
        if (count_next == '0)                  state_d = IDLE;
        else if (wait_d == WW'(MAX_WAIT))      state_d = FORCE;
      end
      FORCE: begin
        if (count_next == '0) state_d = IDLE;
        else if (pop)         state_d = PEND;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs.
  always_comb begin
    ArbStall = (state_q == FORCE);
    PendBusy = any_valid;
  end

`ifdef WB_PORT_ARBITER_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] squash_count_q, squash_count_d;
  logic [31:0] bypass_count_q, bypass_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    squash_count_d = squash_count_q;
    bypass_count_d = bypass_count_q;
    if (ArbStall && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + 32'd1;
    // One count per cycle with any squash, buffered or incoming.
    if ((squash_hit || in_discard) && (squash_count_q != '1)) squash_count_d = squash_count_q + 32'd1;
    if (bypass && (bypass_count_q != '1)) bypass_count_d = bypass_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_q <= '0;
      squash_count_q <= '0;
      bypass_count_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      squash_count_q <= squash_count_d;
      bypass_count_q <= bypass_count_d;
    end
  end

  assign PerfStall  = stall_cycles_q;
  assign PerfSquash = squash_count_q;
  assign PerfBypass = bypass_count_q;
`else
  logic perf_unused;
  assign perf_unused = squash_hit;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_port_arbiter
// Directed scenarios followed by randomized traffic, each cycle compared
// against a queue-based reference model of the arbiter's rules.
// -----------------------------------------------------------------------------
module tb_wb_port_arbiter;

  localparam int V        = 256;
  localparam int R        = 5;
  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;

  typedef struct {
    bit           valid;
    logic [R-1:0] addr;
    logic [V-1:0] data;
  } ent_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         RegWriteVWi = 1'b0;
  logic [R-1:0] WA3Wi = '0;
  logic [V-1:0] ResultVWi = '0;
  logic         LvValid = 1'b0;
  logic         LvReady;
  logic [R-1:0] LvWA3 = '0;
  logic [V-1:0] LvData = '0;
  logic         WEV3;
  logic [R-1:0] WAV3;
  logic [V-1:0] WDV3;
  logic         ArbStall;
  logic         PendBusy;
`ifdef WB_PORT_ARBITER_PERF_EN
  logic [31:0]  PerfStall, PerfSquash, PerfBypass;
`endif

  wb_port_arbiter #(.V(V), .R(R), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk         (clk),
    .rst         (rst_n),
    .RegWriteVWi (RegWriteVWi),
    .WA3Wi       (WA3Wi),
    .ResultVWi   (ResultVWi),
    .LvValid     (LvValid),
    .LvReady     (LvReady),
    .LvWA3       (LvWA3),
    .LvData      (LvData),
    .WEV3        (WEV3),
    .WAV3        (WAV3),
    .WDV3        (WDV3),
    .ArbStall    (ArbStall),
    .PendBusy    (PendBusy)
`ifdef WB_PORT_ARBITER_PERF_EN
    ,
    .PerfStall   (PerfStall),
    .PerfSquash  (PerfSquash),
    .PerfBypass  (PerfBypass)
`endif
  );

  always #5 clk = ~clk;

  // Reference model state.
  ent_t q[$];
  int   blocked_m;
  bit   stall_m;
  int   cyc;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string tag, input logic [V-1:0] obs, input logic [V-1:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [V-1:0] rnd_data();
    logic [V-1:0] r;
    r = '0;
    for (int i = 0; i < V / 32; i++) r = {r[V-33:0], 32'($urandom())};
    return r;
  endfunction

  // One clock: drive, compare against the model, then advance the model.
  task automatic cycle(input bit rw, input logic [R-1:0] wa, input logic [V-1:0] res,
                       input bit lvv, input logic [R-1:0] lwa, input logic [V-1:0] ld,
                       output bit accepted);
    int           n;
    bit           ready, xfer, e_we, e_busy, blocked, popped, do_push;
    logic [R-1:0] e_wa;
    logic [V-1:0] e_wd;
    ent_t         e;
    @(negedge clk);
    RegWriteVWi = rw; WA3Wi = wa; ResultVWi = res;
    LvValid = lvv; LvWA3 = lwa; LvData = ld;
    #1;
    n     = q.size();
    ready = (n < DEPTH);
    xfer  = lvv && ready;
    e_we = 1'b0; e_wa = '0; e_wd = '0;
    if (rw) begin
      e_we = 1'b1; e_wa = wa; e_wd = res;
    end else if (n > 0 && q[0].valid) begin
      e_we = 1'b1; e_wa = q[0].addr; e_wd = q[0].data;
    end else if (n == 0 && xfer) begin
      e_we = 1'b1; e_wa = lwa; e_wd = ld;
    end
    e_busy = 1'b0;
    foreach (q[i]) if (q[i].valid) e_busy = 1'b1;
    check("WEV3", V'(WEV3), V'(e_we));
    check("WAV3", V'(WAV3), V'(e_wa));
    check("WDV3", WDV3, e_wd);
    check("LvReady", V'(LvReady), V'(ready));
    check("ArbStall", V'(ArbStall), V'(stall_m));
    check("PendBusy", V'(PendBusy), V'(e_busy));
    $display("cyc %0d rw=%0d wa=%0d lvv=%0d lwa=%0d -> we=%0d wav=%0d rdy=%0d stall=%0d busy=%0d n=%0d",
             cyc, rw, wa, lvv, lwa, WEV3, WAV3, LvReady, ArbStall, PendBusy, n);
    // Advance the model.
    blocked = rw && n > 0 && q[0].valid;
    if (rw) foreach (q[i]) if (q[i].addr == wa) q[i].valid = 1'b0;
    popped = !rw && n > 0;
    if (popped) void'(q.pop_front());
    do_push = xfer && !(n == 0 && !rw) && !(rw && lwa == wa);
    if (do_push) begin
      e.valid = 1'b1; e.addr = lwa; e.data = ld;
      q.push_back(e);
    end
    if (popped) blocked_m = 0;
    else if (blocked && blocked_m < MAX_WAIT) blocked_m++;
    if (q.size() == 0 || popped) stall_m = 1'b0;
    else if (blocked_m == MAX_WAIT) stall_m = 1'b1;
    accepted = xfer;
    cyc++;
  endtask

  task automatic idle(input int k);
    bit a;
    for (int i = 0; i < k; i++) cycle(1'b0, '0, '0, 1'b0, '0, '0, a);
  endtask

  initial begin : main
    bit           acc;
    bit           lv_pend;
    logic [R-1:0] lv_a;
    logic [V-1:0] lv_d;
    logic [V-1:0] a5;
    cyc = 0; blocked_m = 0; stall_m = 1'b0;
    a5 = {32{8'hA5}};

    repeat (2) @(negedge clk);
    #1;
    check("reset_WEV3", V'(WEV3), V'(1'b0));
    check("reset_ArbStall", V'(ArbStall), V'(1'b0));
    check("reset_PendBusy", V'(PendBusy), V'(1'b0));
    rst_n = 1'b1;
    #1;
    check("release_LvReady", V'(LvReady), V'(1'b1));

    // Bypass into an empty buffer.
    cycle(1'b0, '0, '0, 1'b1, 5'd7, a5, acc);
    idle(1);
    // Pipeline wins, requester result buffered and drained next.
    cycle(1'b1, 5'd3, rnd_data(), 1'b1, 5'd9, rnd_data(), acc);
    idle(2);
    // Fill while the pipeline writes every cycle; third request held.
    lv_d = rnd_data();
    cycle(1'b1, 5'd1, rnd_data(), 1'b1, 5'd10, rnd_data(), acc);
    cycle(1'b1, 5'd2, rnd_data(), 1'b1, 5'd11, rnd_data(), acc);
    cycle(1'b1, 5'd4, rnd_data(), 1'b1, 5'd13, lv_d, acc);
    cycle(1'b0, '0, '0, 1'b1, 5'd13, lv_d, acc);
    cycle(1'b0, '0, '0, 1'b1, 5'd13, lv_d, acc);
    idle(3);
    // Squash of a buffered entry for reg 12.
    cycle(1'b1, 5'd1, rnd_data(), 1'b1, 5'd12, rnd_data(), acc);
    cycle(1'b1, 5'd12, rnd_data(), 1'b0, '0, '0, acc);
    idle(2);
    // Same-cycle discard of an incoming result.
    cycle(1'b1, 5'd6, rnd_data(), 1'b1, 5'd6, rnd_data(), acc);
    idle(1);
    // Starvation: head blocked by consecutive pipeline writes.
    cycle(1'b1, 5'd1, rnd_data(), 1'b1, 5'd20, rnd_data(), acc);
    for (int i = 0; i < 5; i++) cycle(1'b1, 5'(i + 2), rnd_data(), 1'b0, '0, '0, acc);
    idle(3);

    // Reset with two entries buffered.
    cycle(1'b1, 5'd1, rnd_data(), 1'b1, 5'd21, rnd_data(), acc);
    cycle(1'b1, 5'd2, rnd_data(), 1'b1, 5'd22, rnd_data(), acc);
    @(negedge clk);
    rst_n = 1'b0; RegWriteVWi = 1'b1; WA3Wi = 5'd5; LvValid = 1'b0;
    #1;
    check("inrst_WEV3", V'(WEV3), V'(1'b1));
    check("inrst_WAV3", V'(WAV3), V'(5'd5));
    check("inrst_ArbStall", V'(ArbStall), V'(1'b0));
    check("inrst_PendBusy", V'(PendBusy), V'(1'b0));
    @(negedge clk);
    RegWriteVWi = 1'b0;
    #1;
    check("inrst_WEV3_off", V'(WEV3), V'(1'b0));
    rst_n = 1'b1;
    q.delete(); blocked_m = 0; stall_m = 1'b0;
    #1;
    check("post_rst_LvReady", V'(LvReady), V'(1'b1));
    check("post_rst_WEV3", V'(WEV3), V'(1'b0));
    idle(2);

    // Randomized traffic; requester holds its request until accepted.
    lv_pend = 1'b0; lv_a = '0; lv_d = '0;
    for (int i = 0; i < 800; i++) begin
      if (!lv_pend && $urandom_range(0, 1) == 1) begin
        lv_pend = 1'b1;
        lv_a = 5'($urandom_range(0, 7));
        lv_d = rnd_data();
      end
      cycle($urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), rnd_data(),
            lv_pend, lv_a, lv_d, acc);
      if (acc) lv_pend = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
